// File: rtl/fwd_hazard_ctrl_if.sv
// Purpose: ID-stage hazard bus between decode and the forwarding/stall controller.
// Latency: wires only; the controller answers combinationally in the same cycle.
// Backpressure: STALL from the controller holds PC and IF/ID; there is no other flow control.
interface fwd_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 8
) ();
    logic [REG_W-1:0] ID_RA;
    logic [REG_W-1:0] ID_RB;
    logic             ID_RA_USED;
    logic             ID_RB_USED;
    logic [REG_W-1:0] ID_RD;
    logic             ID_RF_LE;
    logic             ID_LOAD;
    logic             FLUSH;
    logic [1:0]       FWD_A_S;
    logic [1:0]       FWD_B_S;
    logic             STALL;
    logic [CNT_W-1:0] STALL_CNT;

    // Decode side drives the ID instruction fields and observes the controller outputs
    modport master (
        output ID_RA, ID_RB, ID_RA_USED, ID_RB_USED, ID_RD, ID_RF_LE, ID_LOAD, FLUSH,
        input  FWD_A_S, FWD_B_S, STALL, STALL_CNT
    );

    // Controller side
    modport slave (
        input  ID_RA, ID_RB, ID_RA_USED, ID_RB_USED, ID_RD, ID_RF_LE, ID_LOAD, FLUSH,
        output FWD_A_S, FWD_B_S, STALL, STALL_CNT
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Purpose: operand forwarding selects and load-use stall from a 3-entry EX/MEM/WB shadow pipe.
// Latency: selects and STALL are combinational from ID inputs and registered entries.
// Backpressure: STALL holds IF/ID for one cycle and injects a bubble into EX; FLUSH overrides it.
module fwd_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    fwd_hazard_ctrl_if.slave bus
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             load;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '{valid: 1'b0, rd: '0, load: 1'b0};

    shadow_t          ex_q;
    shadow_t          mem_q;
    shadow_t          wb_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             stall;
    logic             match_a;
    logic             match_b;

    // Youngest valid producer of a nonzero source wins; r0 never forwards
    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src,
                                           input shadow_t ex, input shadow_t mem,
                                           input shadow_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && (src != '0)) begin
            if (ex.valid && (ex.rd == src))
                sel = 2'b01;
            else if (mem.valid && (mem.rd == src))
                sel = 2'b10;
            else if (wb.valid && (wb.rd == src))
                sel = 2'b11;
        end
        return sel;
    endfunction

    // Operand selects are driven even while stalling; the consumer ignores them then
    always_comb begin
        bus.FWD_A_S = fwd_sel(bus.ID_RA_USED, bus.ID_RA, ex_q, mem_q, wb_q);
        bus.FWD_B_S = fwd_sel(bus.ID_RB_USED, bus.ID_RB, ex_q, mem_q, wb_q);
    end

    // Load in EX feeding a used source in ID needs one bubble; a squashed ID needs none
    always_comb begin
        match_a = bus.ID_RA_USED && (bus.ID_RA != '0) && (bus.ID_RA == ex_q.rd);
        match_b = bus.ID_RB_USED && (bus.ID_RB != '0) && (bus.ID_RB == ex_q.rd);
        stall   = !bus.FLUSH && ex_q.valid && ex_q.load && (ex_q.rd != '0)
                  && (match_a || match_b);
    end

    assign bus.STALL     = stall;
    assign bus.STALL_CNT = stall_cnt_q;

    // Shadow pipeline advance; a stalled or flushed ID slot enters EX as a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= SHADOW_EMPTY;
            mem_q <= SHADOW_EMPTY;
            wb_q  <= SHADOW_EMPTY;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (stall || bus.FLUSH)
                ex_q <= SHADOW_EMPTY;
            else
                ex_q <= '{valid: bus.ID_RF_LE, rd: bus.ID_RD, load: bus.ID_LOAD};
        end
    end

    // Saturating stall-cycle counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Purpose: directed and random checks of fwd_hazard_ctrl against an instruction-history model.
// Latency: outputs sampled 1 time unit after inputs change, away from the rising edge.
// Backpressure: model issues a bubble whenever it predicts a stall or a flush.
module tb_fwd_hazard_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fwd_hazard_ctrl_if #(.REG_W(5), .CNT_W(8)) bus ();

    fwd_hazard_ctrl #(.REG_W(5), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the last three issued slots, index 0 = most recently issued (now in EX)
    logic       h_wr  [3];
    logic [4:0] h_rd  [3];
    logic       h_ld  [3];
    int         m_cnt;

    logic [1:0] last_a;
    logic [1:0] last_b;
    logic       last_stall;
    logic [7:0] last_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_sel(input logic used, input logic [4:0] src);
        if (!used || src == 5'd0) return 2'd0;
        for (int age = 0; age < 3; age++)
            if (h_wr[age] && h_rd[age] == src) return 2'(age + 1);
        return 2'd0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            h_wr[i] = 1'b0;
            h_rd[i] = 5'd0;
            h_ld[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    // Called just after a falling edge; leaves the bench just after the next falling edge
    task automatic step(input logic [4:0] ra, input logic rau, input logic [4:0] rb,
                        input logic rbu, input logic [4:0] rd, input logic le,
                        input logic ld, input logic fl);
        logic e_stall;
        bus.ID_RA = ra; bus.ID_RA_USED = rau;
        bus.ID_RB = rb; bus.ID_RB_USED = rbu;
        bus.ID_RD = rd; bus.ID_RF_LE = le; bus.ID_LOAD = ld; bus.FLUSH = fl;
        #1;
        e_stall = !fl && h_wr[0] && h_ld[0] && h_rd[0] != 5'd0 &&
                  ((rau && ra != 5'd0 && ra == h_rd[0]) || (rbu && rb != 5'd0 && rb == h_rd[0]));
        last_a     = bus.FWD_A_S;
        last_b     = bus.FWD_B_S;
        last_stall = bus.STALL;
        last_cnt   = bus.STALL_CNT;
        check("fwd_a", 32'(last_a), 32'(model_sel(rau, ra)));
        check("fwd_b", 32'(last_b), 32'(model_sel(rbu, rb)));
        check("stall", 32'(last_stall), 32'(e_stall));
        check("stall_cnt", 32'(last_cnt), 32'(m_cnt));
        for (int i = 2; i > 0; i--) begin
            h_wr[i] = h_wr[i-1]; h_rd[i] = h_rd[i-1]; h_ld[i] = h_ld[i-1];
        end
        if (e_stall || fl) begin
            h_wr[0] = 1'b0; h_rd[0] = 5'd0; h_ld[0] = 1'b0;
        end else begin
            h_wr[0] = le; h_rd[0] = rd; h_ld[0] = ld;
        end
        if (e_stall && m_cnt < 255) m_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.ID_RA = '0; bus.ID_RB = '0; bus.ID_RA_USED = 1'b0; bus.ID_RB_USED = 1'b0;
        bus.ID_RD = '0; bus.ID_RF_LE = 1'b0; bus.ID_LOAD = 1'b0; bus.FLUSH = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Reset state, with a consumer of r1 that has no producers
        step(5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 0);
        check("rst_sel_a", 32'(last_a), 32'd0);
        check("rst_stall", 32'(last_stall), 32'd0);
        check("rst_cnt", 32'(last_cnt), 32'd0);

        // ADD r3, then readers of r3 at distance 1, 2, 3, 4
        step(5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0);
        step(5'd3, 1, 5'd0, 0, 5'd9, 1, 0, 0);
        check("dist1_ex", 32'(last_a), 32'd1);
        step(5'd3, 1, 5'd0, 0, 5'd10, 1, 0, 0);
        check("dist2_mem", 32'(last_a), 32'd2);
        step(5'd3, 1, 5'd0, 0, 5'd11, 1, 0, 0);
        check("dist3_wb", 32'(last_a), 32'd3);
        step(5'd3, 1, 5'd0, 0, 5'd12, 1, 0, 0);
        check("dist4_rf", 32'(last_a), 32'd0);

        // r5 written twice back to back: EX beats MEM
        step(5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
        step(5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
        step(5'd0, 0, 5'd5, 1, 5'd0, 0, 0, 0);
        check("ex_beats_mem", 32'(last_b), 32'd1);

        // LDW r7 then a reader of r7: one stall cycle, then MEM forward
        step(5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0);
        step(5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0);
        check("lu_stall", 32'(last_stall), 32'd1);
        check("lu_cnt_before", 32'(last_cnt), 32'd0);
        step(5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0);
        check("lu_stall_gone", 32'(last_stall), 32'd0);
        check("lu_fwd_mem", 32'(last_a), 32'd2);
        check("lu_cnt_after", 32'(last_cnt), 32'd1);

        // Producer of r0 (load) and reader of r0
        step(5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);
        step(5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0);
        check("r0_fwd_a", 32'(last_a), 32'd0);
        check("r0_stall", 32'(last_stall), 32'd0);

        // Load-use with FLUSH in the same cycle
        step(5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0);
        step(5'd7, 1, 5'd0, 0, 5'd7, 1, 0, 1);
        check("flush_no_stall", 32'(last_stall), 32'd0);
        step(5'd0, 0, 5'd7, 1, 5'd0, 0, 0, 0);
        check("flush_bubble_mem", 32'(last_b), 32'd2);
        check("flush_cnt_same", 32'(last_cnt), 32'd1);

        // Reset in the middle of a stall clears the hazard
        step(5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0);
        step(5'd6, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        check("mid_stall", 32'(last_stall), 32'd1);
        do_reset();
        step(5'd6, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        check("post_rst_stall", 32'(last_stall), 32'd0);
        check("post_rst_cnt", 32'(last_cnt), 32'd0);

        // 300 load-use stalls saturate the counter at 255
        for (int i = 0; i < 300; i++) begin
            logic [4:0] r;
            r = 5'($urandom_range(1, 31));
            step(5'd0, 0, 5'd0, 0, r, 1, 1, 0);
            step(5'd0, 0, r, 1, 5'd0, 0, 0, 0);
            step(5'd0, 0, r, 1, 5'd0, 0, 0, 0);
        end
        step(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        check("cnt_saturated", 32'(last_cnt), 32'd255);
        do_reset();
        step(5'd4, 1, 5'd4, 1, 5'd0, 0, 0, 0);
        check("sat_rst_cnt", 32'(last_cnt), 32'd0);
        check("sat_rst_a", 32'(last_a), 32'd0);
        check("sat_rst_b", 32'(last_b), 32'd0);
        check("sat_rst_stall", 32'(last_stall), 32'd0);

        // Random traffic over a small register set to provoke collisions
        for (int i = 0; i < 2000; i++) begin
            step(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Sequencing controller for the 4:1 5-bit/operand-select muxes in the pipelined PA-RISC core.
- Tracks destination-register numbers of instructions in EX, MEM and WB in an internal 3-entry shadow pipeline.
- Drives the 2-bit selects of the two ID-stage operand forwarding muxes, and raises a load-use stall that holds IF/ID and injects a bubble into EX.
- Sits beside the ID/EX pipeline registers. Fed by decode; consumed by the operand muxes and the PC/IF-ID enables.

Parameters:
- REG_W, 5, register-number width.
- CNT_W, 8, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- ID_RA  in  REG_W  source register A of the instruction in ID.
- ID_RB  in  REG_W  source register B of the instruction in ID.
- ID_RA_USED  in  1  instruction in ID reads RA.
- ID_RB_USED  in  1  instruction in ID reads RB.
- ID_RD  in  REG_W  destination register of the instruction in ID.
- ID_RF_LE  in  1  instruction in ID writes the register file.
- ID_LOAD  in  1  instruction in ID is a load.
- FLUSH  in  1  squash the instruction in ID (taken branch/nullify).
- FWD_A_S  out  2  select for operand-A mux.
- FWD_B_S  out  2  select for operand-B mux.
- STALL  out  1  hold PC and IF/ID; insert bubble into EX.
- STALL_CNT  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Shadow entries EX, MEM and WB each hold {valid, rd, load}.
- Entry valid = ID_RF_LE captured and not a bubble.
- Each clock with reset=0:
  - WB<=MEM; MEM<=EX.
  - EX<=bubble (valid=0) if STALL=1 or FLUSH=1; otherwise EX<={ID_RF_LE, ID_RD, ID_LOAD}.
- Selects are combinational, zero latency, from current ID inputs and registered entries. Per operand X in {A,B}:
  - 00 if X unused or ID_RX==0. r0 is hardwired zero and is never forwarded.
  - else 01 if EX.valid and EX.rd==ID_RX.
  - else 10 if MEM.valid and MEM.rd==ID_RX.
  - else 11 if WB.valid and WB.rd==ID_RX.
  - else 00 (register file).
  - Priority is EX > MEM > WB; the youngest producer wins.
- Load-use:
  - STALL=1 when FLUSH=0 and EX.valid and EX.load and EX.rd!=0 and EX.rd matches a used, nonzero ID_RA or ID_RB.
  - STALL is combinational, lasts exactly 1 cycle per load-use: next cycle the load is in MEM and the select becomes 10.
  - While STALL=1, FWD_*_S are still driven per the rules above; the consumer ignores them.
- FLUSH and STALL in the same cycle: FLUSH wins, STALL forced 0, EX gets a bubble.
- STALL_CNT:
  - Increments on each clock where STALL=1.
  - Saturates at all-ones, no wrap.
  - Cleared only by reset.
- Reset:
  - All entries valid=0, rd=0, load=0.
  - STALL_CNT=0.
  - Hence FWD_A_S=FWD_B_S=00 and STALL=0 in the cycle after reset.
  - Reset asserted mid-stall clears the pending hazard; no stall is issued after reset deasserts.
- Non-register-writing instructions (RF_LE=0) occupy a slot as valid=0 and never match.

Test Plan:
- ADD r3 issued, then next instr reads RA=r3 -> FWD_A_S=01. One cycle later (with an intervening independent instr) -> 10. Two intervening -> 11. Three -> 00.
- r5 written by two consecutive instrs, third reads RB=r5 -> FWD_B_S=01 (EX beats MEM).
- LDW into r7, next instr reads RA=r7 -> STALL=1 for exactly 1 cycle, EX bubble, STALL_CNT 0->1; following cycle STALL=0, FWD_A_S=10.
- Producer writes r0, consumer reads r0 (load or ALU) -> FWD=00, STALL=0.
- Load-use hazard with FLUSH=1 same cycle -> STALL=0, next cycle EX.valid=0, STALL_CNT unchanged.
- Force 300 load-use stalls with CNT_W=8 -> STALL_CNT holds 255. Then assert reset one cycle -> STALL_CNT=0, all selects 00, STALL=0.
